// File: rtl/encoder_value_counter.sv
// Quadrature rotary-encoder front end: 2-flop synchronisers, per-channel
// debounce, one count per detent on the rising edge of debounced A, and an
// 8-bit up/down counter that either saturates or wraps. VALUE feeds the
// two-digit hex display directly; STEP_PULSE/DIR serve other consumers.
module encoder_value_counter #(
    parameter int DEBOUNCE_BITS = 4,
    parameter int STEP          = 1,
    parameter int WRAP          = 0
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       ENC_A,
    input  logic       ENC_B,
    input  logic       CLR,
    output logic [7:0] VALUE,
    output logic       STEP_PULSE,
    output logic       DIR
);

    localparam logic [DEBOUNCE_BITS-1:0] CNT_MAX = '1;
    localparam logic [DEBOUNCE_BITS-1:0] CNT_ONE = DEBOUNCE_BITS'(1);
    localparam logic signed [9:0]        STEP_S  = 10'(STEP);

    // Clamp a signed intermediate into the 0..255 display range.
    function automatic logic [7:0] saturate_u8(input logic signed [9:0] x);
        if (x > 10'sd255) begin
            return 8'hFF;
        end else if (x < 10'sd0) begin
            return 8'h00;
        end
        return x[7:0];
    endfunction

    // Apply one detent of STEP to the current value, wrapping or clipping.
    function automatic logic [7:0] step_value(input logic [7:0] cur, input logic up);
        logic signed [9:0] sum;
        if (up) begin
            sum = $signed({2'b00, cur}) + STEP_S;
        end else begin
            sum = $signed({2'b00, cur}) - STEP_S;
        end
        if (WRAP != 0) begin
            return sum[7:0];
        end
        return saturate_u8(sum);
    endfunction

    // _p0 is the first synchroniser flop (s1), _p1 the second (s2).
    logic a_sync_p0, a_sync_p1;
    logic b_sync_p0, b_sync_p1;

    logic                     a_stable, b_stable;
    logic [DEBOUNCE_BITS-1:0] a_cnt, b_cnt;

    logic a_flip, b_flip;
    logic detent;
    logic detent_up;

    // A debounced level flips once the synchronised pin has disagreed with it
    // for the full window; the flip edge is also the detent edge.
    assign a_flip    = (a_sync_p1 != a_stable) && (a_cnt == CNT_MAX);
    assign b_flip    = (b_sync_p1 != b_stable) && (b_cnt == CNT_MAX);
    assign detent    = a_flip && a_sync_p1;
    // Direction uses the pre-update B level, even if B flips on the same edge.
    assign detent_up = ~b_stable;

    // Two-flop synchronisers; idle-high pins reset to 1.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            a_sync_p0 <= 1'b1;
            a_sync_p1 <= 1'b1;
            b_sync_p0 <= 1'b1;
            b_sync_p1 <= 1'b1;
        end else begin
            a_sync_p0 <= ENC_A;
            a_sync_p1 <= a_sync_p0;
            b_sync_p0 <= ENC_B;
            b_sync_p1 <= b_sync_p0;
        end
    end

    // Channel A debounce: any agreement with the stable level restarts the window.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            a_stable <= 1'b1;
            a_cnt    <= '0;
        end else if (a_sync_p1 == a_stable) begin
            a_cnt <= '0;
        end else if (a_flip) begin
            a_stable <= a_sync_p1;
            a_cnt    <= '0;
        end else begin
            a_cnt <= a_cnt + CNT_ONE;
        end
    end

    // Channel B debounce, identical rule to channel A.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            b_stable <= 1'b1;
            b_cnt    <= '0;
        end else if (b_sync_p1 == b_stable) begin
            b_cnt <= '0;
        end else if (b_flip) begin
            b_stable <= b_sync_p1;
            b_cnt    <= '0;
        end else begin
            b_cnt <= b_cnt + CNT_ONE;
        end
    end

    // Counter and detent outputs; CLR wins over the value update only.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            VALUE      <= 8'h00;
            STEP_PULSE <= 1'b0;
            DIR        <= 1'b0;
        end else begin
            STEP_PULSE <= detent;
            if (detent) begin
                DIR <= detent_up;
            end
            if (CLR) begin
                VALUE <= 8'h00;
            end else if (detent) begin
                VALUE <= step_value(VALUE, detent_up);
            end
        end
    end

endmodule

// File: tb/tb_encoder_value_counter.sv
// Bench for encoder_value_counter: three instances with different STEP/WRAP
// share one stimulus stream. A cycle-level reference model predicts the
// debounced levels from the raw pin history and queues expected detents; a
// monitor compares every DUT output against the model on the falling edge.
`timescale 1ns/1ps
module tb_encoder_value_counter;

    localparam int DB  = 4;
    localparam int WIN = 1 << DB;
    localparam int N   = 3;
    localparam int S0  = 1;
    localparam int S1  = 16;
    localparam int S2  = 100;

    typedef struct {
        int val;
        bit dir;
        int edge_n;
    } exp_t;

    logic       CLK    = 1'b0;
    logic       RESETN = 1'b0;
    logic       ENC_A  = 1'b1;
    logic       ENC_B  = 1'b1;
    logic       CLR    = 1'b0;
    logic [7:0] value [N];
    logic       pulse [N];
    logic       dir   [N];

    int   n_tests = 0;
    int   n_fail  = 0;
    int   edge_n  = 0;
    bit   hist_a[$];
    bit   hist_b[$];
    bit   st_a, st_b;
    int   mval [N];
    bit   mdir [N];
    exp_t sb [N][$];

    encoder_value_counter #(.DEBOUNCE_BITS(DB), .STEP(S0), .WRAP(0)) dut0 (
        .CLK(CLK), .RESETN(RESETN), .ENC_A(ENC_A), .ENC_B(ENC_B), .CLR(CLR),
        .VALUE(value[0]), .STEP_PULSE(pulse[0]), .DIR(dir[0]));
    encoder_value_counter #(.DEBOUNCE_BITS(DB), .STEP(S1), .WRAP(1)) dut1 (
        .CLK(CLK), .RESETN(RESETN), .ENC_A(ENC_A), .ENC_B(ENC_B), .CLR(CLR),
        .VALUE(value[1]), .STEP_PULSE(pulse[1]), .DIR(dir[1]));
    encoder_value_counter #(.DEBOUNCE_BITS(DB), .STEP(S2), .WRAP(0)) dut2 (
        .CLK(CLK), .RESETN(RESETN), .ENC_A(ENC_A), .ENC_B(ENC_B), .CLR(CLR),
        .VALUE(value[2]), .STEP_PULSE(pulse[2]), .DIR(dir[2]));

    always #5 CLK = ~CLK;

    function automatic int step_of(input int i);
        case (i)
            0:       return S0;
            1:       return S1;
            default: return S2;
        endcase
    endfunction

    function automatic bit wrap_of(input int i);
        return (i == 1);
    endfunction

    // Value after one detent, from plain integer arithmetic.
    function automatic int apply_step(input int cur, input bit up, input int i);
        int r;
        r = up ? cur + step_of(i) : cur - step_of(i);
        if (wrap_of(i)) return (r + 256) % 256;
        if (r > 255) return 255;
        if (r < 0) return 0;
        return r;
    endfunction

    // True when the WIN raw samples taken 2..WIN+1 edges ago all equal level.
    function automatic bit run_of(input bit q[$], input bit level);
        for (int i = 0; i < WIN; i++) begin
            if (q[q.size() - 2 - i] != level) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        hist_a.delete();
        hist_b.delete();
        for (int i = 0; i <= WIN; i++) begin
            hist_a.push_back(1'b1);
            hist_b.push_back(1'b1);
        end
        st_a = 1'b1;
        st_b = 1'b1;
        for (int i = 0; i < N; i++) begin
            mval[i] = 0;
            mdir[i] = 1'b0;
            sb[i].delete();
        end
    endtask

    task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d t=%0t: got %0d expected %0d", nm, idx, $time, act, exp);
        end
    endtask

    // Reference model: advances on every rising edge, resets asynchronously.
    initial begin
        bit   new_a, new_b, rise, up;
        exp_t e;
        model_reset();
        forever begin
            @(posedge CLK or negedge RESETN);
            if (!RESETN) begin
                model_reset();
            end else begin
                edge_n++;
                new_a = st_a;
                new_b = st_b;
                if (run_of(hist_a, !st_a)) new_a = !st_a;
                if (run_of(hist_b, !st_b)) new_b = !st_b;
                rise = !st_a && new_a;
                up   = !st_b;
                for (int i = 0; i < N; i++) begin
                    if (CLR) mval[i] = 0;
                    else if (rise) mval[i] = apply_step(mval[i], up, i);
                    if (rise) begin
                        mdir[i]  = up;
                        e.val    = mval[i];
                        e.dir    = up;
                        e.edge_n = edge_n;
                        sb[i].push_back(e);
                    end
                end
                st_a = new_a;
                st_b = new_b;
                hist_a.push_back(ENC_A);
                void'(hist_a.pop_front());
                hist_b.push_back(ENC_B);
                void'(hist_b.pop_front());
            end
        end
    end

    // Monitor: samples outputs 1 ns after each falling clock edge or reset assertion.
    initial begin
        bit   exp_pulse;
        exp_t e;
        forever begin
            @(negedge CLK or negedge RESETN);
            #1;
            for (int i = 0; i < N; i++) begin
                if (!RESETN) begin
                    check("reset_value", i, value[i], 0);
                    check("reset_pulse", i, pulse[i], 0);
                    check("reset_dir", i, dir[i], 0);
                end else begin
                    exp_pulse = (sb[i].size() != 0) && (sb[i][0].edge_n == edge_n);
                    check("step_pulse", i, pulse[i], exp_pulse);
                    if (exp_pulse) begin
                        e = sb[i].pop_front();
                        check("detent_value", i, value[i], e.val);
                        check("detent_dir", i, dir[i], e.dir);
                    end
                    check("value", i, value[i], mval[i]);
                    check("dir", i, dir[i], mdir[i]);
                end
            end
        end
    end

    task automatic hold(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic detent(input bit up);
        if (ENC_B != !up) begin
            ENC_B = !up;
            hold(20);
        end
        ENC_A = 1'b0;
        hold(18);
        ENC_A = 1'b1;
        hold(18);
    endtask

    // Stimulus: directed scenarios, then randomized pin activity.
    initial begin
        int r;
        hold(4);
        RESETN = 1'b1;
        hold(25);

        // First up detent after reset.
        ENC_B = 1'b0;
        hold(25);
        ENC_A = 1'b0;
        hold(25);
        ENC_A = 1'b1;
        hold(30);

        // Short high glitch on A, then a real rise.
        ENC_A = 1'b0;
        hold(25);
        ENC_A = 1'b1;
        hold(10);
        ENC_A = 1'b0;
        hold(40);
        ENC_A = 1'b1;
        hold(30);

        // Floor: clear, then down from 00; then wrap back up.
        CLR = 1'b1;
        hold(1);
        CLR = 1'b0;
        hold(2);
        detent(1'b0);
        detent(1'b0);
        detent(1'b1);

        // Ceiling: enough up detents to pin the saturating counters at FF.
        for (int k = 0; k < 260; k++) detent(1'b1);

        // CLR coinciding with the detent edge.
        ENC_B = 1'b0;
        ENC_A = 1'b0;
        hold(25);
        ENC_A = 1'b1;
        hold(17);
        CLR = 1'b1;
        hold(1);
        CLR = 1'b0;
        hold(20);

        // Reset in the middle of a pending A rise.
        for (int k = 0; k < 3; k++) detent(1'b1);
        ENC_A = 1'b0;
        hold(25);
        ENC_A = 1'b1;
        hold(10);
        RESETN = 1'b0;
        hold(2);
        RESETN = 1'b1;
        hold(60);

        // Randomized toggling with mixed hold lengths.
        for (int k = 0; k < 700; k++) begin
            r = $urandom_range(0, 99);
            if (r < 10) begin
                ENC_A = ~ENC_A;
                ENC_B = ~ENC_B;
            end else if (r < 50) begin
                ENC_A = ~ENC_A;
            end else if (r < 85) begin
                ENC_B = ~ENC_B;
            end else if (r < 96) begin
                CLR = 1'b1;
                hold(1);
                CLR = 1'b0;
            end else begin
                RESETN = 1'b0;
                hold(1);
                RESETN = 1'b1;
            end
            hold($urandom_range(1, 40));
        end

        hold(40);
        #3;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
